rvv_backend_dispatch_vrf_scoreboard: RTL
========================================

# rvv_backend_dispatch_vrf_scoreboard

Per-architectural-register scoreboard of in-flight VRF writes, sitting beside the intra-group uop-vs-uop RAW check in the dispatch stage. It counts dispatched-but-not-retired uops that write each of the 32 vector registers and reports, per dispatch slot, whether vs1/vs2/vd(vs3)/v0 sources still have an outstanding producer in the ROB. Dispatch ORs these flags with the intra-group RAW result to stall. Counts rise on dispatch fire and fall on retire.

## Interface
Parameters:
- DISP_NUM, 2, dispatch slots per cycle (query and increment ports)
- RETIRE_NUM, 4, retire ports per cycle (decrement ports)
- CNT_W, 4, counter width per register; CNT_MAX = 2^CNT_W-1

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- disp_fire  input  DISP_NUM  slot i uop accepted by ROB this cycle
- disp_w_vrf  input  DISP_NUM  slot i writes the VRF (w_type==VRF)
- disp_w_index  input  DISP_NUM x 5  slot i destination register
- q_vs1_index / q_vs2_index / q_vd_index  input  DISP_NUM x 5 each  slot i source indices
- q_vs1_valid / q_vs2_valid / q_vs3_valid  input  DISP_NUM each  source used
- q_vm  input  DISP_NUM  1 = unmasked (v0 not read)
- q_vs1_wait / q_vs2_wait / q_vd_wait / q_v0_wait  output  DISP_NUM each  outstanding producer exists
- q_full  output  DISP_NUM  slot i destination counter cannot absorb another DISP_NUM increments
- rt_valid  input  RETIRE_NUM  retire port j retiring a uop
- rt_w_vrf  input  RETIRE_NUM  retiring uop wrote the VRF
- rt_w_index  input  RETIRE_NUM x 5  retiring uop destination
- flush  input  1  trap/ROB flush: discard all in-flight state
- err_underflow  output  1  sticky: a decrement hit a zero counter

## Operation
- State: cnt[0..31], CNT_W bits each; err_underflow flop.
- inc[r] = number of slots i with disp_fire[i] & disp_w_vrf[i] & disp_w_index[i]==r (0..DISP_NUM).
- dec[r] = number of ports j with rt_valid[j] & rt_w_vrf[j] & rt_w_index[j]==r (0..RETIRE_NUM).
- Next-state priority: flush > update. flush=1: all cnt <= 0 next cycle; same-cycle inc/dec ignored; err_underflow unaffected.
- Update: cnt[r] <= cnt[r] + inc[r] - dec[r], computed at CNT_W+2 bits. Result < 0: cnt[r] <= 0, err_underflow <= 1. Result > CNT_MAX cannot occur when dispatch honours q_full; if it does, clamp to CNT_MAX (no error flag).
- Same register incremented and decremented in one cycle: net applied; e.g. cnt=1, inc=1, dec=1 -> 1.
- Queries read registered cnt only (no bypass of same-cycle dispatch or retire):
  - q_vs1_wait[i] = q_vs1_valid[i] & (cnt[q_vs1_index[i]] != 0); vs2 likewise
  - q_vd_wait[i] = q_vs3_valid[i] & (cnt[q_vd_index[i]] != 0)
  - q_v0_wait[i] = ~q_vm[i] & (cnt[0] != 0)
  - q_full[i] = cnt[disp_w_index[i]] > CNT_MAX - DISP_NUM (independent of disp_fire)
- Intra-group dependencies (slot 1 on slot 0) are not covered here; the dispatch uop-vs-uop RAW check handles them.
- err_underflow clears only on reset.

## Timing
- Reset (rst_n low, async): all cnt = 0, err_underflow = 0; therefore all q_*_wait = 0, q_full = 0.
- Query outputs combinational from flops plus query inputs; zero-cycle latency.
- Dispatch at cycle N is visible in waits at N+1; retire at N clears wait at N+1 (one extra stall cycle vs bypass, by design).
- Flush at N: all waits 0 from N+1.
- Reset asserted mid-operation discards all counts immediately; no recovery of in-flight state.

## Test plan
- Reset then query vs1=3 valid, vm=0 on both slots -> all waits 0, q_full 0, err_underflow 0.
- Fire slot0 writing v5 (VRF) at N; query slot1 vs2=5 valid -> q_vs2_wait 0 at N, 1 at N+1; retire v5 at N+3 -> wait 1 at N+3, 0 at N+4.
- Fire v0 writer, then query vm=0 -> q_v0_wait 1; same query with vm=1 -> 0; q_vs3_valid=0 with vd=0 -> q_vd_wait 0.
- Both slots fire writes to v7 each cycle for 7 cycles (CNT_W=4) -> cnt=14, q_full for v7 asserted from cnt 14; simultaneous 2 fires + 2 retires on v7 -> cnt unchanged.
- Four retire ports retire v9 while cnt[v9]=2 -> cnt[v9]=0, err_underflow 1 and stays 1 through flush.
- cnt[v4]=3, flush together with a fire to v4 -> cnt[v4]=0 next cycle, q_vs1_wait for v4 = 0.

Source files
------------

// File: rtl/rvv_backend_dispatch_vrf_scoreboard.sv
// Per-register count of dispatched-but-unretired VRF writers; answers, per dispatch
// slot, whether each vector source still has an outstanding producer in the ROB.
module rvv_backend_dispatch_vrf_scoreboard #(
    parameter int DISP_NUM   = 2,
    parameter int RETIRE_NUM = 4,
    parameter int CNT_W      = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DISP_NUM-1:0]        disp_fire,
    input  logic [DISP_NUM-1:0]        disp_w_vrf,
    input  logic [DISP_NUM-1:0][4:0]   disp_w_index,
    input  logic [DISP_NUM-1:0][4:0]   q_vs1_index,
    input  logic [DISP_NUM-1:0][4:0]   q_vs2_index,
    input  logic [DISP_NUM-1:0][4:0]   q_vd_index,
    input  logic [DISP_NUM-1:0]        q_vs1_valid,
    input  logic [DISP_NUM-1:0]        q_vs2_valid,
    input  logic [DISP_NUM-1:0]        q_vs3_valid,
    input  logic [DISP_NUM-1:0]        q_vm,
    output logic [DISP_NUM-1:0]        q_vs1_wait,
    output logic [DISP_NUM-1:0]        q_vs2_wait,
    output logic [DISP_NUM-1:0]        q_vd_wait,
    output logic [DISP_NUM-1:0]        q_v0_wait,
    output logic [DISP_NUM-1:0]        q_full,
    input  logic [RETIRE_NUM-1:0]      rt_valid,
    input  logic [RETIRE_NUM-1:0]      rt_w_vrf,
    input  logic [RETIRE_NUM-1:0][4:0] rt_w_index,
    input  logic                       flush,
    output logic                       err_underflow
);

    localparam int SUM_W   = CNT_W + 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] FULL_THR = CNT_W'(CNT_MAX - DISP_NUM);

    logic [CNT_W-1:0] cnt_reg  [32];
    logic [CNT_W-1:0] cnt_next [32];
    logic [31:0]      underflow_vec;
    logic             err_underflow_reg;

    genvar gi;

    // Two guard bits: the top bit is the sign of cnt + inc - dec.
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            logic [SUM_W-1:0] inc_cnt;
            logic [SUM_W-1:0] dec_cnt;
            logic [SUM_W-1:0] sum;

            always_comb begin
                inc_cnt = '0;
                dec_cnt = '0;
                for (int i = 0; i < DISP_NUM; i++) begin
                    if (disp_fire[i] && disp_w_vrf[i] && (disp_w_index[i] == 5'(gi)))
                        inc_cnt = inc_cnt + SUM_W'(1);
                end
                for (int j = 0; j < RETIRE_NUM; j++) begin
                    if (rt_valid[j] && rt_w_vrf[j] && (rt_w_index[j] == 5'(gi)))
                        dec_cnt = dec_cnt + SUM_W'(1);
                end
                sum = {2'b00, cnt_reg[gi]} + inc_cnt - dec_cnt;
            end

            assign underflow_vec[gi] = sum[SUM_W-1];
            assign cnt_next[gi] = sum[SUM_W-1]              ? '0 :
                                  (sum > SUM_W'(CNT_MAX))   ? CNT_W'(CNT_MAX) :
                                                              sum[CNT_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) cnt_reg[r] <= '0;
            err_underflow_reg <= 1'b0;
        end else if (flush) begin
            for (int r = 0; r < 32; r++) cnt_reg[r] <= '0;
        end else begin
            for (int r = 0; r < 32; r++) cnt_reg[r] <= cnt_next[r];
            if (|underflow_vec) err_underflow_reg <= 1'b1;
        end
    end

    assign err_underflow = err_underflow_reg;

    // Queries see registered counts only; same-cycle dispatch/retire is not bypassed.
    generate
        for (gi = 0; gi < DISP_NUM; gi++) begin : g_query
            assign q_vs1_wait[gi] = q_vs1_valid[gi] & (cnt_reg[q_vs1_index[gi]] != '0);
            assign q_vs2_wait[gi] = q_vs2_valid[gi] & (cnt_reg[q_vs2_index[gi]] != '0);
            assign q_vd_wait[gi]  = q_vs3_valid[gi] & (cnt_reg[q_vd_index[gi]] != '0);
            assign q_v0_wait[gi]  = ~q_vm[gi] & (cnt_reg[0] != '0);
            assign q_full[gi]     = cnt_reg[disp_w_index[gi]] > FULL_THR;
        end
    endgenerate

endmodule
